// File: rtl/multi_cycle_adder.sv
// Sequential adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock, LSB slice first,
// with a registered carry between slices and a Start/Busy/Done handshake.
module multi_cycle_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = DIGIT + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [DIGIT:0]   slice;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operands shift right each slice so the active slice is always in the low DIGIT bits;
    // the partial sum fills from the top and shifts down into place.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + SW'(cy_q);

        case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = Sub ? ~B[WIDTH-1] : B[WIDTH-1];
                    cy_d    = Sub | Cin;
                    cnt_d   = '0;
                    psum_d  = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d    = a_q >> DIGIT;
                b_d    = b_q >> DIGIT;
                cy_d   = slice[DIGIT];
                psum_d = (psum_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = StDone;
                    sum_d   = psum_d;
                    carry_d = slice[DIGIT];
                    ovf_d   = (a_msb_q == b_msb_q) && (psum_d[WIDTH-1] != a_msb_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign Sum      = sum_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;
    assign Busy     = (state_q == StRun);
    assign Done     = (state_q == StDone);

endmodule
